// File: rtl/bp_be_fe_queue_mt_if.sv
// Fetch-packet handshake bundle between the FE, the thread-tagged queue and
// the BE scheduler. The slave modport is the queue itself; the master modport
// is the surrounding FE/BE logic that feeds and drains it.
interface bp_be_fe_queue_mt_if #(
  parameter int data_width_p      = 128,
  parameter int thread_id_width_p = 1
);
  // FE -> queue
  logic [data_width_p-1:0]      fe_queue_i;
  logic [thread_id_width_p-1:0] fe_queue_tid_i;
  logic                         fe_queue_v_i;
  logic                         fe_queue_ready_and_o;
  // queue -> BE scheduler
  logic [data_width_p-1:0]      fe_queue_o;
  logic                         fe_queue_v_o;
  logic                         fe_queue_ready_and_i;

  modport master (
    output fe_queue_i, fe_queue_tid_i, fe_queue_v_i, fe_queue_ready_and_i,
    input  fe_queue_ready_and_o, fe_queue_o, fe_queue_v_o
  );

  modport slave (
    input  fe_queue_i, fe_queue_tid_i, fe_queue_v_i, fe_queue_ready_and_i,
    output fe_queue_ready_and_o, fe_queue_o, fe_queue_v_o
  );
endinterface

// File: rtl/bp_be_fe_queue_mt.sv
// Thread-tagged FE->BE fetch queue. Every entry carries the thread id it was
// fetched for; a head entry whose tag differs from the BE's active thread is
// popped automatically and counted, so the scheduler only ever sees packets
// for the running context. flush_i empties the queue in a single cycle.
//
// Optional build macro BP_FE_QUEUE_MT_BYPASS_EN: when the queue is empty and
// the incoming packet belongs to the active thread, it is presented to the BE
// in the same cycle (and not stored if the BE takes it). Without the macro
// there is no combinational input-to-output path.
module bp_be_fe_queue_mt #(
  parameter int els_p             = 8,
  parameter int data_width_p      = 128,
  parameter int thread_id_width_p = 1,
  parameter int drop_ctr_width_p  = 16
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         flush_i,
  input  logic [thread_id_width_p-1:0] current_thread_id_i,
  bp_be_fe_queue_mt_if.slave           fe_if,
  output logic [$clog2(els_p+1)-1:0]   count_o,
  output logic [drop_ctr_width_p-1:0]  drop_count_o
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam int cnt_w_lp = $clog2(els_p+1);
  localparam logic [cnt_w_lp-1:0] els_lp = cnt_w_lp'(els_p);

  // Storage (data path, never reset)
  logic [data_width_p-1:0]      data_mem [els_p];
  logic [thread_id_width_p-1:0] tid_mem  [els_p];

  // Control state
  logic [ptr_w_lp-1:0]         rd_ptr_r, wr_ptr_r;
  logic [cnt_w_lp-1:0]         count_r;
  logic [drop_ctr_width_p-1:0] drop_cnt_r;

  logic                         empty, full;
  logic [thread_id_width_p-1:0] head_tid;
  logic [data_width_p-1:0]      head_data;
  logic                         ready, enq, match, discard, deq, pop, wr_en;
  logic                         v_out;
  logic [data_width_p-1:0]      data_out;

  assign empty     = (count_r == '0);
  assign full      = (count_r == els_lp);
  assign head_tid  = tid_mem[rd_ptr_r];
  assign head_data = data_mem[rd_ptr_r];

  // Handshake, thread match, stale discard and optional same-cycle bypass
  always_comb begin
    ready    = !reset_i && !flush_i && !full;
    enq      = fe_if.fe_queue_v_i && ready;
    match    = !empty && (head_tid == current_thread_id_i);
    discard  = !empty && !match && !flush_i;
    v_out    = match && !flush_i;
    deq      = v_out && fe_if.fe_queue_ready_and_i;
    pop      = deq || discard;
    wr_en    = enq;
    data_out = head_data;
`ifdef BP_FE_QUEUE_MT_BYPASS_EN
    // Empty queue and a packet for the running thread: hand it straight over.
    // If the BE takes it this cycle it never touches storage.
    if (empty && !flush_i && !reset_i && fe_if.fe_queue_v_i &&
        (fe_if.fe_queue_tid_i == current_thread_id_i)) begin
      v_out    = 1'b1;
      data_out = fe_if.fe_queue_i;
      if (fe_if.fe_queue_ready_and_i) begin
        wr_en = 1'b0;
      end
    end
`endif
  end

  assign fe_if.fe_queue_ready_and_o = ready;
  assign fe_if.fe_queue_v_o         = v_out;
  assign fe_if.fe_queue_o           = data_out;
  assign count_o                    = count_r;
  assign drop_count_o               = drop_cnt_r;

  // Write the incoming packet and its thread tag at the tail
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      data_mem[wr_ptr_r] <= fe_if.fe_queue_i;
      tid_mem[wr_ptr_r]  <= fe_if.fe_queue_tid_i;
    end
  end

  // Pointer and occupancy update; flush and reset both empty the queue
  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (wr_en) wr_ptr_r <= wr_ptr_r + ptr_w_lp'(1);
      if (pop)   rd_ptr_r <= rd_ptr_r + ptr_w_lp'(1);
      count_r <= count_r + cnt_w_lp'(wr_en) - cnt_w_lp'(pop);
    end
  end

  // Saturating count of stale entries discarded; survives flush
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      drop_cnt_r <= '0;
    end else if (discard && (drop_cnt_r != '1)) begin
      drop_cnt_r <= drop_cnt_r + drop_ctr_width_p'(1);
    end
  end

`ifndef SYNTHESIS
  a_no_enq_full: assert property (@(posedge clk_i) disable iff (reset_i)
    !(fe_if.fe_queue_v_i && fe_if.fe_queue_ready_and_o && full));
  a_no_pop_mismatch: assert property (@(posedge clk_i) disable iff (reset_i)
    !(deq && !match));
`endif

endmodule

// File: tb/tb_bp_be_fe_queue_mt.sv
module tb_bp_be_fe_queue_mt;
  localparam int DW = 128;
  localparam int TW = 1;
  localparam int EL = 8;
  localparam int CW = $clog2(EL+1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          cur_tid = 1'b0;
  logic [CW-1:0] count;
  logic [15:0]   drop;

  logic          flush2 = 1'b0;
  logic          cur_tid2 = 1'b0;
  logic [CW-1:0] count2;
  logic [1:0]    drop2;

  bp_be_fe_queue_mt_if #(.data_width_p(DW), .thread_id_width_p(TW)) qif ();
  bp_be_fe_queue_mt_if #(.data_width_p(DW), .thread_id_width_p(TW)) qif2 ();

  bp_be_fe_queue_mt #(.els_p(EL), .data_width_p(DW), .thread_id_width_p(TW),
                      .drop_ctr_width_p(16)) dut (
    .clk_i(clk), .reset_i(reset), .flush_i(flush),
    .current_thread_id_i(cur_tid), .fe_if(qif),
    .count_o(count), .drop_count_o(drop));

  bp_be_fe_queue_mt #(.els_p(EL), .data_width_p(DW), .thread_id_width_p(TW),
                      .drop_ctr_width_p(2)) dut_sat (
    .clk_i(clk), .reset_i(reset), .flush_i(flush2),
    .current_thread_id_i(cur_tid2), .fe_if(qif2),
    .count_o(count2), .drop_count_o(drop2));

  int total = 0;
  int bad = 0;
  int mdl_drop = 0;
  logic [DW-1:0] sb[$];
  logic [DW-1:0] exp_d;

  initial begin
    qif.fe_queue_i = '0; qif.fe_queue_tid_i = '0; qif.fe_queue_v_i = 1'b0;
    qif.fe_queue_ready_and_i = 1'b0;
    qif2.fe_queue_i = '0; qif2.fe_queue_tid_i = '0; qif2.fe_queue_v_i = 1'b0;
    qif2.fe_queue_ready_and_i = 1'b0;
  end

  // One cycle of stimulus for the main queue; returns just after the falling edge
  task automatic drive(input logic v, input int d, input logic tid,
                       input logic rdy, input logic fl, input logic cur);
    @(negedge clk);
    qif.fe_queue_v_i = v;
    qif.fe_queue_i = DW'(d);
    qif.fe_queue_tid_i = tid;
    qif.fe_queue_ready_and_i = rdy;
    flush = fl;
    cur_tid = cur;
    #1;
  endtask

  task automatic drive2(input logic v, input int d, input logic tid);
    @(negedge clk);
    qif2.fe_queue_v_i = v;
    qif2.fe_queue_i = DW'(d);
    qif2.fe_queue_tid_i = tid;
    #1;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    total++;
    if (qif.fe_queue_ready_and_o !== 1'b0) begin
      bad++; $display("FAIL reset_ready_during got=%b want=0", qif.fe_queue_ready_and_o);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (qif.fe_queue_ready_and_o !== 1'b1) begin
      bad++; $display("FAIL reset_ready_after got=%b want=1", qif.fe_queue_ready_and_o);
    end
    total++;
    if (count !== '0 || drop !== '0 || qif.fe_queue_v_o !== 1'b0) begin
      bad++; $display("FAIL reset_state got cnt=%0d drop=%0d v=%b want 0 0 0", count, drop, qif.fe_queue_v_o);
    end
    total++;
    if (count2 !== '0 || drop2 !== '0) begin
      bad++; $display("FAIL reset_state_sat got cnt=%0d drop=%0d want 0 0", count2, drop2);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 9; i++) begin
      drive(1, 32'h100 + i, 0, 0, 0, 0);
      total++;
      if (qif.fe_queue_ready_and_o !== (i < 8)) begin
        bad++; $display("FAIL fill_ready[%0d] got=%b want=%b", i, qif.fe_queue_ready_and_o, (i < 8));
      end
      total++;
      if (qif.fe_queue_v_o !== (i > 0)) begin
        bad++; $display("FAIL fill_v[%0d] got=%b want=%b", i, qif.fe_queue_v_o, (i > 0));
      end
      if (i < 8) sb.push_back(DW'(32'h100 + i));
    end
    drive(0, 0, 0, 0, 0, 0);
    total++;
    if (count !== CW'(8) || qif.fe_queue_ready_and_o !== 1'b0) begin
      bad++; $display("FAIL full_state got cnt=%0d rdy=%b want 8 0", count, qif.fe_queue_ready_and_o);
    end
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 1, 0, 0);
      total++;
      if (qif.fe_queue_v_o !== 1'b1) begin
        bad++; $display("FAIL drain_v[%0d] got=%b want=1", i, qif.fe_queue_v_o);
      end
      if (qif.fe_queue_v_o && qif.fe_queue_ready_and_i) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL drain_extra got=%h want=none", qif.fe_queue_o);
        end else begin
          exp_d = sb.pop_front();
          if (qif.fe_queue_o !== exp_d) begin
            bad++; $display("FAIL drain_data got=%h want=%h", qif.fe_queue_o, exp_d);
          end
        end
      end
    end
    drive(0, 0, 0, 1, 0, 0);
    total++;
    if (count !== '0 || qif.fe_queue_v_o !== 1'b0 || sb.size() != 0) begin
      bad++; $display("FAIL drain_end got cnt=%0d v=%b left=%0d want 0 0 0", count, qif.fe_queue_v_o, sb.size());
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h200 + i, 0, 0, 0, 0);
      sb.push_back(DW'(32'h200 + i));
    end
    for (int i = 3; i < 23; i++) begin
      drive(1, 32'h200 + i, 0, 1, 0, 0);
      total++;
      if (count !== CW'(3) || qif.fe_queue_ready_and_o !== 1'b1 || qif.fe_queue_v_o !== 1'b1) begin
        bad++; $display("FAIL wrap_state[%0d] got cnt=%0d rdy=%b v=%b want 3 1 1", i, count, qif.fe_queue_ready_and_o, qif.fe_queue_v_o);
      end
      if (qif.fe_queue_v_o && qif.fe_queue_ready_and_i) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL wrap_extra got=%h want=none", qif.fe_queue_o);
        end else begin
          exp_d = sb.pop_front();
          if (qif.fe_queue_o !== exp_d) begin
            bad++; $display("FAIL wrap_data got=%h want=%h", qif.fe_queue_o, exp_d);
          end
        end
      end
      sb.push_back(DW'(32'h200 + i));
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 0, 0);
      if (qif.fe_queue_v_o && qif.fe_queue_ready_and_i) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL wrap_extra got=%h want=none", qif.fe_queue_o);
        end else begin
          exp_d = sb.pop_front();
          if (qif.fe_queue_o !== exp_d) begin
            bad++; $display("FAIL wrap_data got=%h want=%h", qif.fe_queue_o, exp_d);
          end
        end
      end
    end
    drive(0, 0, 0, 1, 0, 0);
    total++;
    if (count !== '0 || sb.size() != 0 || drop !== 16'(mdl_drop)) begin
      bad++; $display("FAIL wrap_end got cnt=%0d left=%0d drop=%0d want 0 0 %0d", count, sb.size(), drop, mdl_drop);
    end
  endtask

  task automatic test_stale_discard();
    logic [3:0] tags;
    tags = 4'b0110;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) drive(1, 32'h300 + i, tags[i], 1, 0, 0);
      else       drive(0, 0, 0, 1, 0, 0);
      if (qif.fe_queue_v_o && qif.fe_queue_ready_and_i) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL stale_extra got=%h want=none", qif.fe_queue_o);
        end else begin
          exp_d = sb.pop_front();
          if (qif.fe_queue_o !== exp_d) begin
            bad++; $display("FAIL stale_data got=%h want=%h", qif.fe_queue_o, exp_d);
          end
        end
      end
      if (i < 4 && tags[i] == 1'b0) sb.push_back(DW'(32'h300 + i));
    end
    mdl_drop += 2;
    total++;
    if (drop !== 16'(mdl_drop) || count !== '0 || sb.size() != 0) begin
      bad++; $display("FAIL stale_end got drop=%0d cnt=%0d left=%0d want %0d 0 0", drop, count, sb.size(), mdl_drop);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) drive(1, 32'h400 + i, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    total++;
    if (count !== CW'(5) || qif.fe_queue_v_o !== 1'b1) begin
      bad++; $display("FAIL flush_pre got cnt=%0d v=%b want 5 1", count, qif.fe_queue_v_o);
    end
    drive(1, 32'h499, 0, 0, 1, 0);
    total++;
    if (qif.fe_queue_ready_and_o !== 1'b0 || qif.fe_queue_v_o !== 1'b0) begin
      bad++; $display("FAIL flush_cycle got rdy=%b v=%b want 0 0", qif.fe_queue_ready_and_o, qif.fe_queue_v_o);
    end
    drive(0, 0, 0, 0, 0, 0);
    total++;
    if (count !== '0 || qif.fe_queue_v_o !== 1'b0 || drop !== 16'(mdl_drop)) begin
      bad++; $display("FAIL flush_after got cnt=%0d v=%b drop=%0d want 0 0 %0d", count, qif.fe_queue_v_o, drop, mdl_drop);
    end
    drive(1, 32'h450, 0, 0, 0, 0);
    sb.push_back(DW'(32'h450));
    drive(0, 0, 0, 1, 0, 0);
    total++;
    if (qif.fe_queue_v_o !== 1'b1) begin
      bad++; $display("FAIL flush_refill_v got=%b want=1", qif.fe_queue_v_o);
    end
    if (qif.fe_queue_v_o && qif.fe_queue_ready_and_i) begin
      total++;
      if (sb.size() == 0) begin
        bad++; $display("FAIL flush_extra got=%h want=none", qif.fe_queue_o);
      end else begin
        exp_d = sb.pop_front();
        if (qif.fe_queue_o !== exp_d) begin
          bad++; $display("FAIL flush_data got=%h want=%h", qif.fe_queue_o, exp_d);
        end
      end
    end
    drive(0, 0, 0, 0, 0, 0);
    total++;
    if (count !== '0) begin
      bad++; $display("FAIL flush_end_cnt got=%0d want=0", count);
    end
  endtask

  task automatic test_thread_switch();
    for (int i = 0; i < 6; i++) begin
      if (i < 3) drive(1, 32'h500 + i, 1, 1, 0, 0);
      else       drive(0, 0, 0, 1, 0, 0);
      total++;
      if (qif.fe_queue_v_o !== 1'b0) begin
        bad++; $display("FAIL switch_stale_v[%0d] got=%b want=0", i, qif.fe_queue_v_o);
      end
    end
    mdl_drop += 3;
    total++;
    if (drop !== 16'(mdl_drop) || count !== '0) begin
      bad++; $display("FAIL switch_stale_end got drop=%0d cnt=%0d want %0d 0", drop, count, mdl_drop);
    end
    drive(1, 32'h600, 1, 0, 0, 0);
    drive(1, 32'h601, 1, 0, 0, 1);
    drive(1, 32'h602, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) sb.push_back(DW'(32'h600 + i));
    drive(0, 0, 0, 0, 0, 1);
    total++;
    if (count !== CW'(3) || qif.fe_queue_v_o !== 1'b1) begin
      bad++; $display("FAIL switch_hold got cnt=%0d v=%b want 3 1", count, qif.fe_queue_v_o);
    end
    cur_tid = 1'b0;
    #1;
    total++;
    if (qif.fe_queue_v_o !== 1'b0) begin
      bad++; $display("FAIL switch_comb_off got=%b want=0", qif.fe_queue_v_o);
    end
    cur_tid = 1'b1;
    #1;
    total++;
    if (qif.fe_queue_v_o !== 1'b1) begin
      bad++; $display("FAIL switch_comb_on got=%b want=1", qif.fe_queue_v_o);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 0, 1);
      if (qif.fe_queue_v_o && qif.fe_queue_ready_and_i) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL switch_extra got=%h want=none", qif.fe_queue_o);
        end else begin
          exp_d = sb.pop_front();
          if (qif.fe_queue_o !== exp_d) begin
            bad++; $display("FAIL switch_data got=%h want=%h", qif.fe_queue_o, exp_d);
          end
        end
      end
    end
    total++;
    if (drop !== 16'(mdl_drop) || count !== '0 || sb.size() != 0) begin
      bad++; $display("FAIL switch_end got drop=%0d cnt=%0d left=%0d want %0d 0 0", drop, count, sb.size(), mdl_drop);
    end
  endtask

  task automatic test_drop_saturation();
    for (int i = 0; i < 5; i++) drive2(1, 32'h700 + i, 1);
    for (int i = 0; i < 4; i++) drive2(0, 0, 0);
    total++;
    if (drop2 !== 2'b11 || count2 !== '0) begin
      bad++; $display("FAIL sat_drop got drop=%0d cnt=%0d want 3 0", drop2, count2);
    end
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    total++;
    if (drop2 !== '0 || drop !== '0 || count !== '0 || qif.fe_queue_ready_and_o !== 1'b0) begin
      bad++; $display("FAIL sat_reset got drop2=%0d drop=%0d cnt=%0d rdy=%b want 0 0 0 0", drop2, drop, count, qif.fe_queue_ready_and_o);
    end
    reset = 1'b0;
    #1;
    total++;
    if (qif.fe_queue_ready_and_o !== 1'b1 || qif2.fe_queue_ready_and_o !== 1'b1) begin
      bad++; $display("FAIL sat_ready_after got=%b/%b want 1/1", qif.fe_queue_ready_and_o, qif2.fe_queue_ready_and_o);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_stale_discard();
    test_flush();
    test_thread_switch();
    test_drop_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
